serial_frame_tx: RTL



---
 rtl/serial_pkg.sv | 29 ++
 rtl/serial_bit_timer.sv | 39 +++
 rtl/serial_frame_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial frame transmitter (and the matching
// receiver that will reuse serial_bit_timer).
//   state_e      : FSM state encoding, 3 bits
//   start_level  : line level of the start bit for a given idle level
//   stop_level   : line level of stop bits / idle for a given idle level
//   frame_bits   : number of bit times in one frame
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   function automatic logic start_level(input logic idle_level);
      return ~idle_level;
   endfunction

   function automatic logic stop_level(input logic idle_level);
      return idle_level;
   endfunction

   function automatic int frame_bits(input int data_w, input int stop_bits, input int p);
      return 1 + data_w + p + stop_bits;
   endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-time counter. Counts 0..div-1 and flags the final clock of each bit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart the count at 0 on the next cycle
//   div         : clocks per bit, must be >= 1
//   last_cycle  : high while count == div-1
module serial_bit_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             last_cycle
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;

   assign last_cycle = (count_q == div - ONE);

   always_comb begin
      count_d = count_q + ONE;
      if (clear || last_cycle) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits, optional parity bit,
// STOP_BITS stop bits. One-entry holding register behind valid/ready lets the
// next word reload at the final stop cycle with no idle gap.
// Build option: define SERIAL_TX_PARITY_EN to add the parity_odd input and a
// parity bit after the data bits.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clk_div      : clocks per bit, sampled at frame start, 0 behaves as 1
//   s_data       : word to send
//   s_valid      : s_data valid
//   s_ready      : holding register empty
//   parity_odd   : (parity builds only) invert parity bit, sampled at frame start
//   tx           : registered serial line
//   busy         : high from first start-bit cycle through last stop-bit cycle
//   done         : one-cycle pulse in the cycle after each frame's last stop cycle
//
// state  | meaning
// IDLE   | line idle, waiting for a held word
// START  | driving start level
// DATA   | shifting out data bits
// PARITY | driving parity bit (parity builds only)
// STOP   | driving stop bits; reloads directly to START if a word is held
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DIV_W      = 16,
   parameter int STOP_BITS  = 1,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
`ifdef SERIAL_TX_PARITY_EN
   input  logic              parity_odd,
`endif
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int                CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [1:0]        STOP_LAST = 2'(STOP_BITS - 1);
   localparam logic              IDLE_LVL  = stop_level(IDLE_LEVEL);
   localparam logic              START_LVL = start_level(IDLE_LEVEL);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]        stop_cnt_q, stop_cnt_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
   logic              par_bit_q, par_bit_d;
`endif

   logic              bit_last;
   logic              timer_clear;
   logic              load;
   logic              accept;
   logic              next_bit;
   logic [DATA_W-1:0] shift_next;

   serial_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (timer_clear),
      .div        (div_q),
      .last_cycle (bit_last)
   );

   // The bit leaving the shifter next, and the shifter after it has left.
   assign next_bit   = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
   assign shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      div_d       = div_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      timer_clear = 1'b0;
      load        = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_bit_d   = par_bit_q;
`endif
      accept      = s_valid && !hold_full_q;

      case (state_q)
         IDLE: begin
            tx_d   = IDLE_LVL;
            busy_d = 1'b0;
            if (hold_full_q) load = 1'b1;
         end
         START: begin
            if (bit_last) begin
               state_d = DATA;
               tx_d    = next_bit;
               shift_d = shift_next;
            end
         end
         DATA: begin
            if (bit_last) begin
               if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d    = PARITY;
                  tx_d       = par_bit_q;
`else
                  state_d    = STOP;
                  tx_d       = IDLE_LVL;
                  stop_cnt_d = '0;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  tx_d      = next_bit;
                  shift_d   = shift_next;
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_last) begin
               state_d    = STOP;
               tx_d       = IDLE_LVL;
               stop_cnt_d = '0;
            end
         end
`endif
         STOP: begin
            if (bit_last) begin
               if (stop_cnt_q == STOP_LAST) begin
                  done_d = 1'b1;
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     tx_d    = IDLE_LVL;
                     busy_d  = 1'b0;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LVL;
            busy_d  = 1'b0;
         end
      endcase

      // Frame start, from IDLE or as a back-to-back reload out of STOP.
      if (load) begin
         state_d     = START;
         shift_d     = hold_q;
         div_d       = (clk_div == '0) ? DIV_ONE : clk_div;
         timer_clear = 1'b1;
         tx_d        = START_LVL;
         busy_d      = 1'b1;
         bit_cnt_d   = '0;
         stop_cnt_d  = '0;
         hold_full_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_bit_d   = (^hold_q) ^ parity_odd;
`endif
      end

      // accept needs an empty holding register and load needs a full one,
      // so the two never coincide.
      if (accept) begin
         hold_d      = s_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         div_q       <= DIV_ONE;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         tx_q        <= IDLE_LVL;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_bit_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         div_q       <= div_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SERIAL_TX_PARITY_EN
         par_bit_q   <= par_bit_d;
`endif
      end
   end

   assign s_ready = ~hold_full_q;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
